// File: rtl/chroma_pkg.sv
// chroma_pkg -- shared definitions for the chroma-key compositor.
//
// Contents:
//   PKG_CW          default bits per colour channel
//   PKG_DEF_GMIN    default green floor threshold
//   PKG_DEF_MARGIN  default green-dominance margin
//   CFG_GMIN/CFG_MARGIN  config register addresses
//   pixel_t         packed R|G|B pixel at the default channel width
package chroma_pkg;

    localparam int PKG_CW         = 4;
    localparam int PKG_DEF_GMIN   = 5;
    localparam int PKG_DEF_MARGIN = 3;

    localparam logic CFG_GMIN   = 1'b0;
    localparam logic CFG_MARGIN = 1'b1;

    // R occupies the MSBs, matching the packed vector layout used on the ports.
    typedef struct packed {
        logic [PKG_CW-1:0] r;
        logic [PKG_CW-1:0] g;
        logic [PKG_CW-1:0] b;
    } pixel_t;

endpackage

// File: rtl/chroma_key_cmp.sv
// chroma_key_cmp -- combinational green-screen decision for one pixel.
//
// Optional feature macro: CHROMA_SOFT_EDGE_EN (adds the border output).
//
// Ports:
//   pix     in   3*CW  pixel, R|G|B with R in MSBs
//   gmin    in   CW    green floor threshold
//   margin  in   CW    green-dominance margin
//   key     out  1     pixel is strongly green (hard key)
//   border  out  1     near-key pixel, only with CHROMA_SOFT_EDGE_EN
//
// Enables (key_en, de, valid) are applied by the caller; this block only
// judges colour.
module chroma_key_cmp #(
    parameter int CW = 4
) (
    input  logic [3*CW-1:0] pix,
    input  logic [CW-1:0]   gmin,
    input  logic [CW-1:0]   margin,
    output logic            key
`ifdef CHROMA_SOFT_EDGE_EN
    ,
    output logic            border
`endif
);

    // One extra bit so R/B + margin cannot wrap: a bright red or blue
    // channel must never let a pixel qualify as green.
    logic [CW:0] r;
    logic [CW:0] g;
    logic [CW:0] b;
    logic [CW:0] m;

    assign r = {1'b0, pix[3*CW-1:2*CW]};
    assign g = {1'b0, pix[2*CW-1:CW]};
    assign b = {1'b0, pix[CW-1:0]};
    assign m = {1'b0, margin};

    assign key = (g > {1'b0, gmin}) && (g > r + m) && (g > b + m);

`ifdef CHROMA_SOFT_EDGE_EN
    logic [CW:0] mh;
    assign mh     = m >> 1;
    assign border = !key && (g > {1'b0, gmin}) && (g > r + mh) && (g > b + mh);
`endif

endmodule

// File: rtl/chroma_key_pipe.sv
// chroma_key_pipe -- two-stage chroma-key compositor for the VGA path.
//
// Optional feature macro: CHROMA_SOFT_EDGE_EN (averages fg/bg on border pixels).
//
// Ports:
//   clk, reset_n           pixel clock, async active-low reset
//   in_valid/in_de/in_sof  input qualifiers (sof meaningful only with valid)
//   in_fg, in_bg           foreground / background pixels, R|G|B
//   key_en                 1 = keying active, 0 = pass-through
//   cfg_we/cfg_addr/cfg_wdata  pending threshold write (0 = GMIN, 1 = MARGIN)
//   out_valid/out_de       inputs delayed by 2 cycles
//   out_rgb, out_key       composited pixel and replaced flag
//   key_count(_valid)      keyed-pixel count of last frame, 1-cycle update pulse
module chroma_key_pipe
    import chroma_pkg::*;
#(
    parameter int CW         = PKG_CW,
    parameter int DEF_GMIN   = PKG_DEF_GMIN,
    parameter int DEF_MARGIN = PKG_DEF_MARGIN,
    parameter int CNT_W      = 17
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic            in_de,
    input  logic            in_sof,
    input  logic [3*CW-1:0] in_fg,
    input  logic [3*CW-1:0] in_bg,
    input  logic            key_en,
    input  logic            cfg_we,
    input  logic            cfg_addr,
    input  logic [CW-1:0]   cfg_wdata,
    output logic            out_valid,
    output logic            out_de,
    output logic [3*CW-1:0] out_rgb,
    output logic            out_key,
    output logic [CNT_W-1:0] key_count,
    output logic            key_count_valid
);

    localparam logic [CW-1:0] GMIN_RST   = CW'(DEF_GMIN);
    localparam logic [CW-1:0] MARGIN_RST = CW'(DEF_MARGIN);

    // ---------------- thresholds ----------------
    logic [CW-1:0] pend_gmin, pend_margin;
    logic [CW-1:0] act_gmin, act_margin;
    logic          take_cfg;
    logic [CW-1:0] eff_gmin, eff_margin;

    assign take_cfg = in_valid && in_sof;
    // The sof pixel itself is judged with the values being promoted.
    assign eff_gmin   = take_cfg ? pend_gmin   : act_gmin;
    assign eff_margin = take_cfg ? pend_margin : act_margin;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values; a cfg write landing on an sof cycle
    // therefore updates pending while active still takes the old pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_gmin   <= GMIN_RST;
            pend_margin <= MARGIN_RST;
            act_gmin    <= GMIN_RST;
            act_margin  <= MARGIN_RST;
        end else begin
            if (cfg_we) begin
                if (cfg_addr == CFG_MARGIN) pend_margin <= cfg_wdata;
                else                        pend_gmin   <= cfg_wdata;
            end
            if (take_cfg) begin
                act_gmin   <= pend_gmin;
                act_margin <= pend_margin;
            end
        end
    end

    // ---------------- stage 1: decision ----------------
    logic cmp_key;
    logic hit;

`ifdef CHROMA_SOFT_EDGE_EN
    logic cmp_border;
    logic edge_hit;
    logic s1_border;

    chroma_key_cmp #(.CW(CW)) u_cmp (
        .pix    (in_fg),
        .gmin   (eff_gmin),
        .margin (eff_margin),
        .key    (cmp_key),
        .border (cmp_border)
    );

    assign edge_hit = in_valid && in_de && key_en && cmp_border;
`else
    chroma_key_cmp #(.CW(CW)) u_cmp (
        .pix    (in_fg),
        .gmin   (eff_gmin),
        .margin (eff_margin),
        .key    (cmp_key)
    );
`endif

    assign hit = in_valid && in_de && key_en && cmp_key;

    logic            s1_valid, s1_de, s1_sof, s1_key;
    logic [3*CW-1:0] s1_fg, s1_bg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_de     <= 1'b0;
            s1_sof    <= 1'b0;
            s1_key    <= 1'b0;
            s1_fg     <= '0;
            s1_bg     <= '0;
`ifdef CHROMA_SOFT_EDGE_EN
            s1_border <= 1'b0;
`endif
        end else begin
            s1_valid  <= in_valid;
            s1_de     <= in_de;
            s1_sof    <= in_valid && in_sof;
            s1_key    <= hit;
            s1_fg     <= in_fg;
            s1_bg     <= in_bg;
`ifdef CHROMA_SOFT_EDGE_EN
            s1_border <= edge_hit;
`endif
        end
    end

    // ---------------- stage 2: composite ----------------
    logic [3*CW-1:0] mix;
`ifdef CHROMA_SOFT_EDGE_EN
    logic [CW:0]     ch_sum;
`endif

    // NOTE: every combinational output is given a default before any branch
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mix = s1_fg;
`ifdef CHROMA_SOFT_EDGE_EN
        ch_sum = '0;
        if (s1_border) begin
            for (int c = 0; c < 3; c++) begin
                ch_sum = {1'b0, s1_fg[c*CW +: CW]} + {1'b0, s1_bg[c*CW +: CW]};
                mix[c*CW +: CW] = ch_sum[CW:1];
            end
        end
`endif
        if (s1_key) mix = s1_bg;
        if (!s1_de) mix = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_de    <= 1'b0;
            out_rgb   <= '0;
            out_key   <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            out_de    <= s1_de;
            out_rgb   <= mix;
            out_key   <= s1_key;
        end
    end

    // ---------------- per-frame keyed-pixel counter ----------------
    // Counting starts at the first sof, so the first report after reset is 0.
    logic [CNT_W-1:0] cnt;
    logic             in_frame;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt             <= '0;
            in_frame        <= 1'b0;
            key_count       <= '0;
            key_count_valid <= 1'b0;
        end else begin
            key_count_valid <= 1'b0;
            if (s1_valid && s1_sof) begin
                key_count       <= cnt;
                key_count_valid <= 1'b1;
                cnt             <= CNT_W'(s1_key);
                in_frame        <= 1'b1;
            end else if (s1_valid && s1_key && in_frame && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chroma_key_pipe.sv
// tb_chroma_key_pipe -- directed self-checking bench for chroma_key_pipe.
// A second instance with CNT_W = 4 shares all inputs to show counter
// saturation; chroma_key_cmp is also exercised on its own.
module tb_chroma_key_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_de = 1'b0, in_sof = 1'b0;
    logic [11:0] in_fg = '0, in_bg = '0;
    logic        key_en = 1'b1;
    logic        cfg_we = 1'b0, cfg_addr = 1'b0;
    logic [3:0]  cfg_wdata = '0;

    logic        out_valid, out_de, out_key, key_count_valid;
    logic [11:0] out_rgb;
    logic [16:0] key_count;

    logic        s_valid, s_de, s_key, s_kcv;
    logic [11:0] s_rgb;
    logic [3:0]  s_count;

    logic [11:0] c_pix;
    logic [3:0]  c_gmin, c_margin;
    logic        c_key;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    chroma_key_pipe u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_de(in_de),
        .in_sof(in_sof), .in_fg(in_fg), .in_bg(in_bg), .key_en(key_en),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(out_valid), .out_de(out_de), .out_rgb(out_rgb),
        .out_key(out_key), .key_count(key_count), .key_count_valid(key_count_valid)
    );

    chroma_key_pipe #(.CNT_W(4)) u_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_de(in_de),
        .in_sof(in_sof), .in_fg(in_fg), .in_bg(in_bg), .key_en(key_en),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(s_valid), .out_de(s_de), .out_rgb(s_rgb),
        .out_key(s_key), .key_count(s_count), .key_count_valid(s_kcv)
    );

`ifdef CHROMA_SOFT_EDGE_EN
    logic c_border;
    chroma_key_cmp #(.CW(4)) u_cmp (
        .pix(c_pix), .gmin(c_gmin), .margin(c_margin), .key(c_key), .border(c_border)
    );
`else
    chroma_key_cmp #(.CW(4)) u_cmp (
        .pix(c_pix), .gmin(c_gmin), .margin(c_margin), .key(c_key)
    );
`endif

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] fg, input logic [11:0] bg,
                        input logic de, input logic sof);
        in_valid = 1'b1;
        in_fg    = fg;
        in_bg    = bg;
        in_de    = de;
        in_sof   = sof;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        tick();
    endtask

    // Runs up to 4 idle cycles after an sof and records the report pulse(s).
    task automatic wait_report(output logic [16:0] cnt_seen, output logic [3:0] sat_seen,
                               output int pulses);
        cnt_seen = '0;
        sat_seen = '0;
        pulses   = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (key_count_valid) begin
                pulses++;
                cnt_seen = key_count;
            end
            if (s_kcv) sat_seen = s_count;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        total++;
        if ({out_valid, out_de, out_key, out_rgb, key_count, key_count_valid} !== '0)
            $display("FAIL reset_outputs: got v=%b de=%b k=%b rgb=%h cnt=%0d kcv=%b want all 0",
                     out_valid, out_de, out_key, out_rgb, key_count, key_count_valid);
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
        tick();
        // Defaults GMIN=5, MARGIN=3: 0x0F0 keys, sof after reset reports 0.
        send(12'h0F0, 12'hABC, 1'b1, 1'b1);
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL latency_early: out_valid=%b after 1 cycle, want 0", out_valid);
        else pass_cnt++;
        idle();
        total++;
        if ({out_valid, out_key, out_rgb} !== {1'b1, 1'b1, 12'hABC})
            $display("FAIL reset_default_key: got v=%b k=%b rgb=%h want v=1 k=1 rgb=abc",
                     out_valid, out_key, out_rgb);
        else pass_cnt++;
        total++;
        if ({key_count_valid, key_count} !== {1'b1, 17'd0})
            $display("FAIL first_sof_report: got kcv=%b cnt=%0d want kcv=1 cnt=0",
                     key_count_valid, key_count);
        else pass_cnt++;
        idle();
        total++;
        if ({out_valid, key_count_valid} !== 2'b00)
            $display("FAIL pulse_width: got v=%b kcv=%b want 0 0", out_valid, key_count_valid);
        else pass_cnt++;
    endtask

    task automatic test_threshold();
        logic [11:0] fgs  [6];
        logic [11:0] exps [6];
        logic        keys [6];
        fgs[0] = 12'h5F5; exps[0] = 12'h123; keys[0] = 1'b1;  // G 15 > 8
        fgs[1] = 12'hCFC; exps[1] = 12'hCFC; keys[1] = 1'b0;  // R+3 = 15 not <
        fgs[2] = 12'h050; exps[2] = 12'h050; keys[2] = 1'b0;  // G = GMIN
        fgs[3] = 12'h060; exps[3] = 12'h123; keys[3] = 1'b1;  // G just above GMIN
        fgs[4] = 12'hFF0; exps[4] = 12'hFF0; keys[4] = 1'b0;  // 15+3 = 18, no wrap
        fgs[5] = 12'hDF0; keys[5] = 1'b0;                     // near-key border
`ifdef CHROMA_SOFT_EDGE_EN
        exps[5] = 12'h781;  // (D+1)>>1, (F+2)>>1, (0+3)>>1
`else
        exps[5] = 12'hDF0;
`endif
        for (int i = 0; i < 6; i++) begin
            send(fgs[i], 12'h123, 1'b1, 1'b0);
            idle();
            total++;
            if ({out_valid, out_key, out_rgb} !== {1'b1, keys[i], exps[i]})
                $display("FAIL threshold_%0d fg=%h: got k=%b rgb=%h want k=%b rgb=%h",
                         i, fgs[i], out_key, out_rgb, keys[i], exps[i]);
            else pass_cnt++;
        end
    endtask

    task automatic check_5f5(input string name, input logic exp_key);
        logic [11:0] exp_rgb;
        exp_rgb = exp_key ? 12'h246 : 12'h5F5;
        total++;
        if ({out_key, out_rgb} !== {exp_key, exp_rgb})
            $display("FAIL %s: got k=%b rgb=%h want k=%b rgb=%h",
                     name, out_key, out_rgb, exp_key, exp_rgb);
        else pass_cnt++;
    endtask

    task automatic test_cfg_frame();
        logic [16:0] c;
        logic [3:0]  s;
        int          p;
        send(12'h000, 12'h246, 1'b1, 1'b1);
        wait_report(c, s, p);
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 4'd10;
        idle();
        cfg_we = 1'b0;
        send(12'h5F5, 12'h246, 1'b1, 1'b0); idle();
        check_5f5("cfg_midframe_old", 1'b1);
        send(12'h5F5, 12'h246, 1'b1, 1'b1); idle();
        check_5f5("cfg_sof_new", 1'b0);
        send(12'h5F5, 12'h246, 1'b1, 1'b0); idle();
        check_5f5("cfg_after_sof", 1'b0);
        // Write coinciding with sof: takes effect at the following sof.
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 4'd3;
        send(12'h5F5, 12'h246, 1'b1, 1'b1);
        cfg_we = 1'b0;
        idle();
        check_5f5("cfg_coincide_sof", 1'b0);
        send(12'h5F5, 12'h246, 1'b1, 1'b0); idle();
        check_5f5("cfg_coincide_mid", 1'b0);
        send(12'h5F5, 12'h246, 1'b1, 1'b1); idle();
        check_5f5("cfg_coincide_next_sof", 1'b1);
    endtask

    task automatic test_counter();
        logic [16:0] c;
        logic [3:0]  s;
        int          p;
        send(12'h000, 12'h111, 1'b1, 1'b1);
        wait_report(c, s, p);
        for (int i = 0; i < 100; i++) send(12'h0F0, 12'h111, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++)  send(12'h000, 12'h111, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)  idle();
        for (int i = 0; i < 10; i++)  send(12'h0F0, 12'h111, 1'b0, 1'b0);
        send(12'h000, 12'h111, 1'b1, 1'b1);
        wait_report(c, s, p);
        total++;
        if (p != 1 || c !== 17'd100)
            $display("FAIL count_100: got pulses=%0d cnt=%0d want pulses=1 cnt=100", p, c);
        else pass_cnt++;
        total++;
        if (s !== 4'd15)
            $display("FAIL count_saturate: got %0d want 15", s);
        else pass_cnt++;
    endtask

    task automatic test_misc();
        logic [16:0] c;
        logic [3:0]  s;
        int          p;
        send(12'h0F0, 12'h777, 1'b0, 1'b0); idle();
        total++;
        if ({out_valid, out_de, out_key, out_rgb} !== {1'b1, 1'b0, 1'b0, 12'h000})
            $display("FAIL de_low: got v=%b de=%b k=%b rgb=%h want v=1 de=0 k=0 rgb=000",
                     out_valid, out_de, out_key, out_rgb);
        else pass_cnt++;

        send(12'h000, 12'h777, 1'b1, 1'b1);
        wait_report(c, s, p);
        key_en = 1'b0;
        for (int i = 0; i < 5; i++) send(12'h0F0, 12'h777, 1'b1, 1'b0);
        idle();
        total++;
        if ({out_key, out_rgb} !== {1'b0, 12'h0F0})
            $display("FAIL key_en_off: got k=%b rgb=%h want k=0 rgb=0f0", out_key, out_rgb);
        else pass_cnt++;
        send(12'h000, 12'h777, 1'b1, 1'b1);
        wait_report(c, s, p);
        key_en = 1'b1;
        total++;
        if (p != 1 || c !== 17'd0)
            $display("FAIL key_en_count: got pulses=%0d cnt=%0d want pulses=1 cnt=0", p, c);
        else pass_cnt++;

        // GMIN=15 makes 0x0F0 unkeyable; reset must restore defaults.
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_wdata = 4'd15;
        idle();
        cfg_we = 1'b0;
        send(12'h000, 12'h777, 1'b1, 1'b1);
        send(12'h0F0, 12'h777, 1'b1, 1'b0); idle();
        total++;
        if ({out_key, out_rgb} !== {1'b0, 12'h0F0})
            $display("FAIL gmin_15: got k=%b rgb=%h want k=0 rgb=0f0", out_key, out_rgb);
        else pass_cnt++;
        send(12'h0F0, 12'h777, 1'b1, 1'b0);
        send(12'h0F0, 12'h777, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_de, out_key, out_rgb, key_count, key_count_valid} !== '0)
            $display("FAIL reset_midframe: got v=%b de=%b k=%b rgb=%h cnt=%0d want all 0",
                     out_valid, out_de, out_key, out_rgb, key_count);
        else pass_cnt++;
        #2;
        reset_n = 1'b1;
        tick();
        send(12'h0F0, 12'h777, 1'b1, 1'b0); idle();
        total++;
        if ({out_key, out_rgb} !== {1'b1, 12'h777})
            $display("FAIL reset_active_default: got k=%b rgb=%h want k=1 rgb=777",
                     out_key, out_rgb);
        else pass_cnt++;
        send(12'h0F0, 12'h777, 1'b1, 1'b1); idle();
        total++;
        if ({out_key, out_rgb} !== {1'b1, 12'h777})
            $display("FAIL reset_pending_default: got k=%b rgb=%h want k=1 rgb=777",
                     out_key, out_rgb);
        else pass_cnt++;
    endtask

    task automatic test_cmp_standalone();
        logic [11:0] pix [8];
        logic [3:0]  gm  [8];
        logic [3:0]  mg  [8];
        logic        ek  [8];
        pix[0] = 12'h5F5; gm[0] = 4'd5;  mg[0] = 4'd3; ek[0] = 1'b1;
        pix[1] = 12'hCFC; gm[1] = 4'd5;  mg[1] = 4'd3; ek[1] = 1'b0;
        pix[2] = 12'h050; gm[2] = 4'd5;  mg[2] = 4'd3; ek[2] = 1'b0;
        pix[3] = 12'hFF0; gm[3] = 4'd5;  mg[3] = 4'd3; ek[3] = 1'b0;
        pix[4] = 12'h0F0; gm[4] = 4'd15; mg[4] = 4'd0; ek[4] = 1'b0;
        pix[5] = 12'h0F0; gm[5] = 4'd14; mg[5] = 4'd0; ek[5] = 1'b1;
        pix[6] = 12'hEFE; gm[6] = 4'd0;  mg[6] = 4'd0; ek[6] = 1'b1;
        pix[7] = 12'h0F0; gm[7] = 4'd0;  mg[7] = 4'd15; ek[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c_pix = pix[i]; c_gmin = gm[i]; c_margin = mg[i];
            #1;
            total++;
            if (c_key !== ek[i])
                $display("FAIL cmp_%0d pix=%h gmin=%0d margin=%0d: got %b want %b",
                         i, pix[i], gm[i], mg[i], c_key, ek[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        c_pix = '0; c_gmin = '0; c_margin = '0;
        test_reset();
        test_threshold();
        test_cfg_frame();
        test_counter();
        test_misc();
        test_cmp_standalone();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
